div_ratio_controller: RTL

DIV_RATIO_CONTROLLER -- requirements
Module: div_ratio_controller

---
 rtl/div_ctrl_pkg.sv | 23 ++
 rtl/div_counter.sv | 50 +++++
 rtl/div_ratio_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the ratio divider controller: ratio codes,
// FSM state encoding and the ratio-code to terminal-count mapping.
package div_ctrl_pkg;

  // Ratio codes: divide by 2^(code+1)
  localparam logic [1:0] DIV2  = 2'b00;
  localparam logic [1:0] DIV4  = 2'b01;
  localparam logic [1:0] DIV8  = 2'b10;
  localparam logic [1:0] DIV16 = 2'b11;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  // Terminal count N-1 for a ratio code, where N = 2^(code+1)
  function automatic logic [15:0] ratio_term(input logic [1:0] code);
    logic [15:0] n;
    n = 16'd2 << code;
    return n - 16'd1;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Period counter for the divider: holds cnt, flags the terminal count of
// the active ratio and registers the divided output bit.
module div_counter
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [1:0]       ratio,
  input  logic [1:0]       next_ratio,
  output logic [CNT_W-1:0] cnt,
  output logic             q_out,
  output logic             at_term
);

  logic [15:0]      term_full;
  logic [CNT_W-1:0] cnt_next;

  // Terminal-count detect against the ratio currently in force
  always_comb begin
    term_full = ratio_term(ratio);
    at_term   = (cnt == term_full[CNT_W-1:0]);
  end

  // Next count: clear takes precedence (idle hold or period wrap)
  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // q_out is loaded with the bit that will be selected next cycle, so it
  // always equals cnt[active_ratio] without a combinational output path
  always_ff @(posedge cp) begin
    if (rst) begin
      cnt   <= '0;
      q_out <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      q_out <= cnt_next[next_ratio];
    end
  end

endmodule

// File: rtl/div_ratio_controller.sv
// Clock-ratio divider controller: IDLE/RUN/PEND FSM with a valid/ready
// ratio handshake. Ratio changes and stops only take effect at period
// boundaries so q_out never shows a truncated phase.
module div_ratio_controller
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_ratio,
  output logic             cfg_ready,
  output logic [1:0]       active_ratio,
  output logic [CNT_W-1:0] cnt,
  output logic             q_out,
  output logic             tick,
  output logic             busy
);

  logic [1:0] state;
  logic [1:0] state_n;
  logic [1:0] ratio_n;
  logic [1:0] pend_ratio;
  logic [1:0] pend_n;
  logic       cnt_clear;
  logic       cnt_inc;
  logic       at_term;
  logic       xfer;

  assign cfg_ready = (state != ST_PEND);
  assign busy      = (state != ST_IDLE);
  assign tick      = busy & at_term;
  assign xfer      = cfg_valid & cfg_ready;

  // Next-state, ratio and counter control; en is only acted on at the
  // terminal count, so dropping and re-raising it mid-period is invisible
  always_comb begin
    state_n   = state;
    ratio_n   = active_ratio;
    pend_n    = pend_ratio;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (xfer) ratio_n = cfg_ratio;
        if (en)   state_n = ST_RUN;
      end
      ST_RUN: begin
        if (at_term) begin
          cnt_clear = 1'b1;
          if (xfer) ratio_n = cfg_ratio;
          if (!en)  state_n = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
          // Same-code offers are absorbed without dropping cfg_ready
          if (xfer && (cfg_ratio != active_ratio)) begin
            pend_n  = cfg_ratio;
            state_n = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (at_term) begin
          cnt_clear = 1'b1;
          ratio_n   = pend_ratio;
          state_n   = en ? ST_RUN : ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_n   = ST_IDLE;
      end
    endcase
  end

  // Control state; reset discards any pending ratio
  always_ff @(posedge cp) begin
    if (rst) begin
      state        <= ST_IDLE;
      active_ratio <= DIV2;
      pend_ratio   <= DIV2;
    end else begin
      state        <= state_n;
      active_ratio <= ratio_n;
      pend_ratio   <= pend_n;
    end
  end

  div_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .cp        (cp),
    .rst       (rst),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .ratio     (active_ratio),
    .next_ratio(ratio_n),
    .cnt       (cnt),
    .q_out     (q_out),
    .at_term   (at_term)
  );

endmodule
